// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-port round-robin arbiter in front of a single-ported data memory
module dmem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_valid,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ready,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_valid,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [6:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state, state_next;
  logic                rr_last;
  logic                cur_id;
  logic                cur_write;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_wdata;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    cnt;
  logic                grant_any;
  logic                grant_id;
  logic                accept;

  // Both ports always see the last captured load data; rvalid says whose it is.
  assign p0_rdata = rdata_q;
  assign p1_rdata = rdata_q;

  // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
  // Ready is masked during reset so every output reads zero while reset is held.
  always_comb begin
    grant_any = p0_valid | p1_valid;
    grant_id  = (p0_valid && p1_valid) ? ~rr_last : p1_valid;
    accept    = (state == IDLE) && grant_any && !reset;
  end

  // Next-state and memory-port decode; a store only asserts SW in its final cycle.
  always_comb begin
    state_next = state;
    p0_ready   = 1'b0;
    p1_ready   = 1'b0;
    p0_rvalid  = 1'b0;
    p1_rvalid  = 1'b0;
    mem_op     = 7'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        p0_ready = accept & ~grant_id;
        p1_ready = accept & grant_id;
        if (accept) state_next = ACCESS;
      end
      ACCESS: begin
        busy      = 1'b1;
        mem_addr  = cur_addr;
        mem_wdata = cur_wdata;
        if (cur_write) mem_op = (cnt == '0) ? OP_SW : 7'b0;
        else           mem_op = OP_LW;
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        p0_rvalid  = ~cur_id;
        p1_rvalid  = cur_id;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight access immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Request latch, latency counter and load-data capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_last   <= 1'b1;
      cur_id    <= 1'b0;
      cur_write <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
    end else if (accept) begin
      rr_last   <= grant_id;
      cur_id    <= grant_id;
      cur_write <= grant_id ? p1_write : p0_write;
      cur_addr  <= grant_id ? p1_addr : p0_addr;
      cur_wdata <= grant_id ? p1_wdata : p0_wdata;
      cnt       <= CNT_W'(MEM_LATENCY - 1);
    end else if (state == ACCESS) begin
      if (cnt == '0) begin
        if (!cur_write) rdata_q <= mem_rdata;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;

  logic clock = 1'b0;
  logic reset;
  logic mem_init;
  always #5 clock = ~clock;

  // latency-1 instance signals
  logic a_p0_valid, a_p0_write, a_p0_ready, a_p0_rvalid;
  logic a_p1_valid, a_p1_write, a_p1_ready, a_p1_rvalid;
  logic [31:0] a_p0_addr, a_p0_wdata, a_p0_rdata, a_p1_addr, a_p1_wdata, a_p1_rdata;
  logic [6:0]  a_mem_op;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_busy;

  // latency-3 instance signals
  logic b_p0_valid, b_p0_write, b_p0_ready, b_p0_rvalid;
  logic b_p1_valid, b_p1_write, b_p1_ready, b_p1_rvalid;
  logic [31:0] b_p0_addr, b_p0_wdata, b_p0_rdata, b_p1_addr, b_p1_wdata, b_p1_rdata;
  logic [6:0]  b_mem_op;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_busy;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset),
    .p0_valid(a_p0_valid), .p0_write(a_p0_write), .p0_addr(a_p0_addr), .p0_wdata(a_p0_wdata),
    .p0_ready(a_p0_ready), .p0_rvalid(a_p0_rvalid), .p0_rdata(a_p0_rdata),
    .p1_valid(a_p1_valid), .p1_write(a_p1_write), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
    .p1_ready(a_p1_ready), .p1_rvalid(a_p1_rvalid), .p1_rdata(a_p1_rdata),
    .mem_op(a_mem_op), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset),
    .p0_valid(b_p0_valid), .p0_write(b_p0_write), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
    .p0_ready(b_p0_ready), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata),
    .p1_valid(b_p1_valid), .p1_write(b_p1_write), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
    .p1_ready(b_p1_ready), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata),
    .mem_op(b_mem_op), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // memory models: combinational read, write on SW at posedge, count writes
  logic [31:0] mem1 [0:15];
  logic [31:0] mem3 [0:15];
  int sw1_cnt, sw3_cnt;
  assign a_mem_rdata = mem1[a_mem_addr[3:0]];
  assign b_mem_rdata = mem3[b_mem_addr[3:0]];

  always @(posedge clock) begin
    if (mem_init) begin
      for (int k = 0; k < 16; k++) begin
        mem1[k] <= 32'h0;
        mem3[k] <= 32'h0;
      end
      mem1[1] <= 32'h11111111; mem1[2] <= 32'h22222222;
      mem3[1] <= 32'h11111111; mem3[2] <= 32'h22222222; mem3[9] <= 32'h00000099;
      sw1_cnt <= 0;
      sw3_cnt <= 0;
    end else begin
      if (a_mem_op == SW) begin
        mem1[a_mem_addr[3:0]] <= a_mem_wdata;
        sw1_cnt <= sw1_cnt + 1;
      end
      if (b_mem_op == SW) begin
        mem3[b_mem_addr[3:0]] <= b_mem_wdata;
        sw3_cnt <= sw3_cnt + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        p0v, p0w;
    logic [31:0] p0a, p0d;
    logic        p1v, p1w;
    logic [31:0] p1a, p1d;
    logic [1:0]  rdy;    // {p1_ready, p0_ready}
    logic [1:0]  rv;     // {p1_rvalid, p0_rvalid}
    logic [6:0]  op;
    logic        busy;
    logic        chk_rd;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic p0v, input logic p0w, input logic [31:0] p0a, input logic [31:0] p0d,
                              input logic p1v, input logic p1w, input logic [31:0] p1a, input logic [31:0] p1d,
                              input logic [1:0] rdy, input logic [1:0] rv, input logic [6:0] op,
                              input logic busy, input logic chk_rd, input logic [31:0] rd);
    vec_t v;
    v.p0v = p0v; v.p0w = p0w; v.p0a = p0a; v.p0d = p0d;
    v.p1v = p1v; v.p1w = p1w; v.p1a = p1a; v.p1d = p1d;
    v.rdy = rdy; v.rv = rv; v.op = op; v.busy = busy; v.chk_rd = chk_rd; v.rd = rd;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // continuous contention from reset: p0 (addr 1) and p1 (addr 2) loads alternate
    for (int g = 0; g < 4; g++) begin
      tbl[g*3+0] = mk(1,0,1,0, 1,0,2,0, (g%2==0) ? 2'b01 : 2'b10, 2'b00, 7'h0, 0, 0, 0);
      tbl[g*3+1] = mk(1,0,1,0, 1,0,2,0, 2'b00, 2'b00, LW, 1, 0, 0);
      tbl[g*3+2] = mk(1,0,1,0, 1,0,2,0, 2'b00, (g%2==0) ? 2'b01 : 2'b10, 7'h0, 1, 1,
                      (g%2==0) ? 32'h11111111 : 32'h22222222);
    end
    // latency 1: store then load back on port 0
    tbl[12] = mk(1,1,5,32'hDEADBEEF, 0,0,0,0, 2'b01, 2'b00, 7'h0, 0, 0, 0);
    tbl[13] = mk(0,0,0,0,            0,0,0,0, 2'b00, 2'b00, SW,   1, 0, 0);
    tbl[14] = mk(0,0,0,0,            0,0,0,0, 2'b00, 2'b01, 7'h0, 1, 1, 32'h22222222);
    tbl[15] = mk(1,0,5,0,            0,0,0,0, 2'b01, 2'b00, 7'h0, 0, 0, 0);
    tbl[16] = mk(0,0,0,0,            0,0,0,0, 2'b00, 2'b00, LW,   1, 0, 0);
    tbl[17] = mk(0,0,0,0,            0,0,0,0, 2'b00, 2'b01, 7'h0, 1, 1, 32'hDEADBEEF);
    tbl[18] = mk(0,0,0,0,            0,0,0,0, 2'b00, 2'b00, 7'h0, 0, 1, 32'hDEADBEEF);

    reset = 1'b1; mem_init = 1'b1;
    {a_p0_valid, a_p0_write, a_p1_valid, a_p1_write} = '0;
    {a_p0_addr, a_p0_wdata, a_p1_addr, a_p1_wdata} = '0;
    {b_p0_valid, b_p0_write, b_p1_valid, b_p1_write} = '0;
    {b_p0_addr, b_p0_wdata, b_p1_addr, b_p1_wdata} = '0;
    repeat (2) @(negedge clock);
    #1;
    chk("reset busy", {31'b0, a_busy}, 32'h0);
    chk("reset mem_op", {25'b0, a_mem_op}, 32'h0);
    mem_init = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clock);
      a_p0_valid = tbl[i].p0v; a_p0_write = tbl[i].p0w; a_p0_addr = tbl[i].p0a; a_p0_wdata = tbl[i].p0d;
      a_p1_valid = tbl[i].p1v; a_p1_write = tbl[i].p1w; a_p1_addr = tbl[i].p1a; a_p1_wdata = tbl[i].p1d;
      #1;
      chk($sformatf("v%0d ready", i),  {30'b0, a_p1_ready, a_p0_ready}, {30'b0, tbl[i].rdy});
      chk($sformatf("v%0d rvalid", i), {30'b0, a_p1_rvalid, a_p0_rvalid}, {30'b0, tbl[i].rv});
      chk($sformatf("v%0d mem_op", i), {25'b0, a_mem_op}, {25'b0, tbl[i].op});
      chk($sformatf("v%0d busy", i),   {31'b0, a_busy}, {31'b0, tbl[i].busy});
      if (tbl[i].chk_rd) begin
        chk($sformatf("v%0d p0_rdata", i), a_p0_rdata, tbl[i].rd);
        chk($sformatf("v%0d p1_rdata", i), a_p1_rdata, tbl[i].rd);
      end
    end
    chk("L1 store count", sw1_cnt, 1);

    // reset asserted in idle with a pending request: outputs clear at once
    @(negedge clock);
    a_p1_valid = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst p1_ready", {31'b0, a_p1_ready}, 32'h0);
    chk("rst mem_op", {25'b0, a_mem_op}, 32'h0);
    chk("rst busy", {31'b0, a_busy}, 32'h0);
    chk("rst rdata", a_p0_rdata, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    a_p1_valid = 1'b0;

    // latency 3 store: SW only on the third access cycle
    @(negedge clock);
    b_p0_valid = 1'b1; b_p0_write = 1'b1; b_p0_addr = 7; b_p0_wdata = 32'hCAFEF00D;
    #1 chk("L3 st ready", {31'b0, b_p0_ready}, 32'h1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      b_p0_valid = 1'b0;
      #1 chk($sformatf("L3 st op c%0d", c), {25'b0, b_mem_op}, (c == 3) ? {25'b0, SW} : 32'h0);
    end
    @(negedge clock); #1;
    chk("L3 st rvalid", {31'b0, b_p0_rvalid}, 32'h1);
    chk("L3 st done op", {25'b0, b_mem_op}, 32'h0);
    chk("L3 st count", sw3_cnt, 1);
    chk("L3 st mem", mem3[7], 32'hCAFEF00D);

    // latency 3 load: LW for three cycles, rvalid on the fourth
    @(negedge clock);
    b_p0_valid = 1'b1; b_p0_write = 1'b0; b_p0_addr = 7;
    #1 chk("L3 ld ready", {31'b0, b_p0_ready}, 32'h1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      b_p0_valid = 1'b0;
      #1;
      chk($sformatf("L3 ld op c%0d", c), {25'b0, b_mem_op}, {25'b0, LW});
      chk($sformatf("L3 ld rv c%0d", c), {31'b0, b_p0_rvalid}, 32'h0);
    end
    @(negedge clock); #1;
    chk("L3 ld rvalid", {31'b0, b_p0_rvalid}, 32'h1);
    chk("L3 ld rdata", b_p0_rdata, 32'hCAFEF00D);

    // reset in the middle of a store: no write, arbitration pointer restored
    @(negedge clock);
    b_p0_valid = 1'b1; b_p0_write = 1'b1; b_p0_addr = 9; b_p0_wdata = 32'h12345678;
    #1 chk("rst st ready", {31'b0, b_p0_ready}, 32'h1);
    @(negedge clock);
    b_p0_valid = 1'b0;
    #1 chk("rst st op a1", {25'b0, b_mem_op}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst st op", {25'b0, b_mem_op}, 32'h0);
    chk("rst st busy", {31'b0, b_busy}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst st count", sw3_cnt, 1);
    chk("rst st mem", mem3[9], 32'h00000099);
    b_p0_valid = 1'b1; b_p0_write = 1'b0; b_p0_addr = 1;
    b_p1_valid = 1'b1; b_p1_write = 1'b0; b_p1_addr = 2;
    #1 chk("rst tie", {30'b0, b_p1_ready, b_p0_ready}, 32'h1);
    b_p0_valid = 1'b0; b_p1_valid = 1'b0;

    // p1 streaming, p0 arrives mid-access and must wait for idle
    @(negedge clock);
    b_p1_valid = 1'b1; b_p1_write = 1'b0; b_p1_addr = 2;
    #1 chk("str p1 ready", {30'b0, b_p1_ready, b_p0_ready}, 32'h2);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      b_p0_valid = 1'b1; b_p0_write = 1'b0; b_p0_addr = 1;
      #1 chk($sformatf("str wait c%0d", c), {30'b0, b_p1_ready, b_p0_ready}, 32'h0);
    end
    @(negedge clock); #1;
    chk("str p1 done", {30'b0, b_p1_rvalid, b_p0_rvalid}, 32'h2);
    chk("str p1 rdata", b_p1_rdata, 32'h22222222);
    chk("str done rdy", {30'b0, b_p1_ready, b_p0_ready}, 32'h0);
    @(negedge clock); #1;
    chk("str p0 wins", {30'b0, b_p1_ready, b_p0_ready}, 32'h1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      b_p0_valid = 1'b0;
      #1 chk($sformatf("str p0 acc c%0d", c), {30'b0, b_p1_rvalid, b_p0_rvalid}, 32'h0);
    end
    @(negedge clock); #1;
    chk("str p0 done", {30'b0, b_p1_rvalid, b_p0_rvalid}, 32'h1);
    chk("str p0 rdata", b_p0_rdata, 32'h11111111);
    @(negedge clock); #1;
    chk("str p1 next", {30'b0, b_p1_ready, b_p0_ready}, 32'h2);
    b_p1_valid = 1'b0;

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
